// File: rtl/axi_mem_slave.sv
// AXI4-style memory slave: independent write (AW/W/B) and read (AR/R) paths over a word array.
// Supports FIXED/INCR/WRAP bursts up to 16 beats and narrow transfers.
module axi_mem_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned MIW   = $clog2(MEM_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Wrap keeps the low bits inside the (len+1)*2^size window and the high bits of the start.
    function automatic addr_t next_addr(addr_t a, logic [3:0] len, logic [2:0] size,
                                        logic fixed, logic wrap);
        addr_t mask, inc;
        mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        inc  = a + (addr_t'(1) << size);
        if (fixed) return a;
        if (wrap) return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    function automatic logic burst_bad(logic [1:0] burst, logic [3:0] len, logic [2:0] size,
                                       addr_t a);
        addr_t amask;
        logic  bad;
        amask = (addr_t'(1) << size) - addr_t'(1);
        case (burst)
            2'b11:   bad = 1'b1;
            2'b10:   bad = !(len inside {4'd1, 4'd3, 4'd7, 4'd15}) || ((a & amask) != '0);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic size_bad(logic [2:0] size);
        return {29'd0, size} > OFFS;
    endfunction

    function automatic logic in_range(addr_t a);
        return (a >> OFFS) < addr_t'(MEM_DEPTH);
    endfunction

    // ---------------- write path ----------------
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, bid_q, bid_d;
    addr_t                 aw_addr_q, aw_addr_d;
    logic [3:0]            aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic                  w_fixed_q, w_fixed_d, w_wrap_q, w_wrap_d, w_nowr_q, w_nowr_d;
    logic                  w_dec_q, w_dec_d, w_slv_q, w_slv_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, b_hs, w_last_beat, mem_we;

    always_comb begin
        aw_hs       = (w_state_q == WIdle) && AWVALID && awready_q;
        w_hs        = (w_state_q == WData) && WVALID && wready_q;
        b_hs        = (w_state_q == WResp) && BREADY && bvalid_q;
        w_last_beat = (w_beat_q == aw_len_q);
        mem_we      = ARESETn && w_hs && !w_nowr_q && in_range(aw_addr_q);
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        aw_addr_d   = aw_addr_q;
        aw_len_d    = aw_len_q;
        aw_size_d   = aw_size_q;
        w_fixed_d   = w_fixed_q;
        w_wrap_d    = w_wrap_q;
        w_nowr_d    = w_nowr_q;
        w_dec_d     = w_dec_q;
        w_slv_d     = w_slv_q;
        w_beat_d    = w_beat_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        unique case (w_state_q)
            WIdle: if (aw_hs) begin
                aw_id_d   = AWID;
                aw_addr_d = AWADDR;
                aw_len_d  = AWLEN;
                aw_size_d = AWSIZE;
                w_fixed_d = (AWBURST == 2'b00);
                w_wrap_d  = (AWBURST == 2'b10) && !burst_bad(AWBURST, AWLEN, AWSIZE, AWADDR);
                w_nowr_d  = size_bad(AWSIZE);
                w_slv_d   = size_bad(AWSIZE) || burst_bad(AWBURST, AWLEN, AWSIZE, AWADDR);
                w_dec_d   = 1'b0;
                w_beat_d  = '0;
                w_state_d = WData;
            end
            WData: if (w_hs) begin
                w_dec_d   = w_dec_q || !in_range(aw_addr_q);
                w_slv_d   = w_slv_q || (WLAST != w_last_beat);
                aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, w_fixed_q, w_wrap_q);
                w_beat_d  = w_beat_q + 4'd1;
                if (w_last_beat) begin
                    w_state_d = WResp;
                    bid_d     = aw_id_q;
                    bresp_d   = w_dec_d ? 2'b11 : (w_slv_d ? 2'b10 : 2'b00);
                end
            end
            WResp: if (b_hs) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
        awready_d = (w_state_d == WIdle);
        wready_d  = (w_state_d == WData);
        bvalid_d  = (w_state_d == WResp);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q <= WIdle;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_size_q <= '0;
            w_fixed_q <= 1'b0;
            w_wrap_q  <= 1'b0;
            w_nowr_q  <= 1'b0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            w_beat_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_id_q   <= aw_id_d;
            aw_addr_q <= aw_addr_d;
            aw_len_q  <= aw_len_d;
            aw_size_q <= aw_size_d;
            w_fixed_q <= w_fixed_d;
            w_wrap_q  <= w_wrap_d;
            w_nowr_q  <= w_nowr_d;
            w_dec_q   <= w_dec_d;
            w_slv_q   <= w_slv_d;
            w_beat_q  <= w_beat_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (WSTRB[b]) mem[aw_addr_q[OFFS +: MIW]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d, rid_q, rid_d;
    addr_t                 ar_addr_q, ar_addr_d, ld_addr;
    logic [3:0]            ar_len_q, ar_len_d, r_beat_q, r_beat_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic                  r_fixed_q, r_fixed_d, r_wrap_q, r_wrap_d, r_nord_q, r_nord_d;
    logic                  r_slv_q, r_slv_d, ld_nord, ld_slv;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, ld_data;
    logic [1:0]            rresp_q, rresp_d, ld_resp;
    logic                  ar_hs, r_hs;

    always_comb begin
        ar_hs   = (r_state_q == RIdle) && ARVALID && arready_q;
        r_hs    = (r_state_q == RData) && rvalid_q && RREADY;
        // In idle the beat being loaded is beat 0 of the incoming request.
        ld_addr = (r_state_q == RIdle) ? ARADDR : ar_addr_q;
        ld_nord = (r_state_q == RIdle) ? size_bad(ARSIZE) : r_nord_q;
        ld_slv  = (r_state_q == RIdle) ? (size_bad(ARSIZE) ||
                                          burst_bad(ARBURST, ARLEN, ARSIZE, ARADDR)) : r_slv_q;
        ld_data = (!in_range(ld_addr) || ld_nord) ? '0 : mem[ld_addr[OFFS +: MIW]];
        ld_resp = !in_range(ld_addr) ? 2'b11 : (ld_slv ? 2'b10 : 2'b00);
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_size_d = ar_size_q;
        r_fixed_d = r_fixed_q;
        r_wrap_d  = r_wrap_q;
        r_nord_d  = r_nord_q;
        r_slv_d   = r_slv_q;
        r_beat_d  = r_beat_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        unique case (r_state_q)
            RIdle: if (ar_hs) begin
                ar_id_d   = ARID;
                ar_len_d  = ARLEN;
                ar_size_d = ARSIZE;
                r_fixed_d = (ARBURST == 2'b00);
                r_wrap_d  = (ARBURST == 2'b10) && !burst_bad(ARBURST, ARLEN, ARSIZE, ARADDR);
                r_nord_d  = ld_nord;
                r_slv_d   = ld_slv;
                ar_addr_d = next_addr(ARADDR, ARLEN, ARSIZE, r_fixed_d, r_wrap_d);
                r_beat_d  = '0;
                rid_d     = ARID;
                rdata_d   = ld_data;
                rresp_d   = ld_resp;
                rlast_d   = (ARLEN == 4'd0);
                rvalid_d  = 1'b1;
                r_state_d = RData;
            end
            RData: if (r_hs) begin
                if (r_beat_q == ar_len_q) begin
                    rvalid_d  = 1'b0;
                    rlast_d   = 1'b0;
                    r_state_d = RIdle;
                end else begin
                    rdata_d   = ld_data;
                    rresp_d   = ld_resp;
                    r_beat_d  = r_beat_q + 4'd1;
                    rlast_d   = ((r_beat_q + 4'd1) == ar_len_q);
                    ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_size_q, r_fixed_q, r_wrap_q);
                end
            end
            default: r_state_d = RIdle;
        endcase
        arready_d = (r_state_d == RIdle);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state_q <= RIdle;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
            r_fixed_q <= 1'b0;
            r_wrap_q  <= 1'b0;
            r_nord_q  <= 1'b0;
            r_slv_q   <= 1'b0;
            r_beat_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
            ar_size_q <= ar_size_d;
            r_fixed_q <= r_fixed_d;
            r_wrap_q  <= r_wrap_d;
            r_nord_q  <= r_nord_d;
            r_slv_q   <= r_slv_d;
            r_beat_q  <= r_beat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: one task per scenario with inline expected-value checks.
module tb_axi_mem_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wd [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic [15:0] rd_last;
    logic [3:0]  rd_id, b_id;
    logic [1:0]  b_resp;
    logic        rv_after_ar, stall_ok, rst_rvalid, rst_arready;

    task automatic timeout_fail(input string what);
        n_cmp++; n_bad++;
        $display("FAIL timeout_%s: got no handshake in 50 cycles, required one", what);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] strb, input logic wlast_ok);
        int k;
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1;
        k = 0; do begin @(negedge ACLK); k++; end while (!AWREADY && k < 50);
        if (!AWREADY) timeout_fail("aw");
        @(posedge ACLK); #1; AWVALID = 0;
        for (int b = 0; b <= len; b++) begin
            WDATA = wd[b]; WSTRB = strb; WLAST = wlast_ok && (b == len); WVALID = 1;
            k = 0; do begin @(negedge ACLK); k++; end while (!WREADY && k < 50);
            if (!WREADY) timeout_fail("w");
            @(posedge ACLK); #1;
        end
        WVALID = 0; WLAST = 0; BREADY = 1;
        k = 0; do begin @(negedge ACLK); k++; end while (!BVALID && k < 50);
        if (!BVALID) timeout_fail("b");
        b_resp = BRESP; b_id = BID;
        @(posedge ACLK); #1; BREADY = 0;
    endtask

    // stall_at: beat on which RREADY is dropped for two cycles; rst_at: beat on which reset hits.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_at, input int rst_at);
        int k;
        logic [31:0] snap_d;
        logic snap_l;
        rd_last = '0; stall_ok = 1;
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1;
        k = 0; do begin @(negedge ACLK); k++; end while (!ARREADY && k < 50);
        if (!ARREADY) timeout_fail("ar");
        @(posedge ACLK); #1; ARVALID = 0;
        rv_after_ar = RVALID; RREADY = 1;
        for (int b = 0; b <= len; b++) begin
            k = 0; do begin @(negedge ACLK); k++; end while (!RVALID && k < 50);
            if (!RVALID) begin timeout_fail("r"); RREADY = 0; return; end
            if (b == rst_at) begin
                ARESETn = 0;
                @(posedge ACLK); #1;
                rst_rvalid = RVALID; rst_arready = ARREADY; RREADY = 0;
                return;
            end
            if (b == stall_at) begin
                snap_d = RDATA; snap_l = RLAST; RREADY = 0;
                repeat (2) begin
                    @(negedge ACLK);
                    if (!RVALID || RDATA !== snap_d || RLAST !== snap_l) stall_ok = 0;
                end
                RREADY = 1;
            end
            rd_data[b] = RDATA; rd_resp[b] = RRESP; rd_last[b] = RLAST; rd_id = RID;
            @(posedge ACLK); #1;
        end
        RREADY = 0;
    endtask

    task automatic test_reset;
        ARESETn = 0;
        repeat (3) @(posedge ACLK);
        #1;
        n_cmp++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
        end
        n_cmp++;
        if ({BID, BRESP, RID, RRESP, RDATA} !== 44'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h, required 0", {BID, BRESP, RID, RRESP, RDATA});
        end
        ARESETn = 1;
        @(posedge ACLK); #1;
        n_cmp++;
        if ({AWREADY, ARREADY, WREADY, BVALID, RVALID} !== 5'b11000) begin
            n_bad++;
            $display("FAIL reset_release: got %b, required 11000",
                     {AWREADY, ARREADY, WREADY, BVALID, RVALID});
        end
    endtask

    task automatic test_single;
        wd[0] = 32'hDEADBEEF;
        do_write(4'd5, 32'h10, 0, 3'd2, 2'b01, 4'hF, 1'b1);
        n_cmp++;
        if ({b_resp, b_id} !== {2'b00, 4'd5}) begin
            n_bad++; $display("FAIL single_b: got resp %b id %0d, required 00 id 5", b_resp, b_id);
        end
        do_read(4'd3, 32'h10, 0, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if ({rv_after_ar, rd_data[0], rd_last[0], rd_resp[0], rd_id} !==
            {1'b1, 32'hDEADBEEF, 1'b1, 2'b00, 4'd3}) begin
            n_bad++;
            $display("FAIL single_r: got rv %b data %h last %b resp %b id %0d, required 1 deadbeef 1 00 3",
                     rv_after_ar, rd_data[0], rd_last[0], rd_resp[0], rd_id);
        end
    endtask

    task automatic test_incr;
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        do_write(4'd1, 32'h100, 3, 3'd2, 2'b01, 4'hF, 1'b1);
        n_cmp++;
        if (b_resp !== 2'b00) begin n_bad++; $display("FAIL incr_b: got %b, required 00", b_resp); end
        do_read(4'd2, 32'h100, 3, 3'd2, 2'b01, 1, -1);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
            n_bad++;
            $display("FAIL incr_data: got %h %h %h %h, required 1 2 3 4",
                     rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        n_cmp++;
        if (rd_last !== 16'h0008) begin
            n_bad++; $display("FAIL incr_last: got %h, required 0008", rd_last);
        end
        n_cmp++;
        if (stall_ok !== 1'b1) begin n_bad++; $display("FAIL incr_stall: got unstable, required stable"); end
        n_cmp++;
        if (RVALID !== 1'b0) begin n_bad++; $display("FAIL incr_end: got RVALID %b, required 0", RVALID); end
    endtask

    task automatic test_wrap;
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
        do_write(4'd0, 32'h0, 3, 3'd2, 2'b01, 4'hF, 1'b1);
        do_read(4'd0, 32'h8, 3, 3'd2, 2'b10, -1, -1);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== {32'hC, 32'hD, 32'hA, 32'hB}) begin
            n_bad++;
            $display("FAIL wrap_data: got %h %h %h %h, required c d a b",
                     rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        n_cmp++;
        if ({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]} !== 8'h00) begin
            n_bad++;
            $display("FAIL wrap_resp: got %b %b %b %b, required 00",
                     rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]);
        end
    endtask

    task automatic test_strobe_fixed;
        wd[0] = 32'hFFFFFFFF;
        do_write(4'd0, 32'h40, 0, 3'd2, 2'b01, 4'hF, 1'b1);
        wd[0] = 32'h11223344;
        do_write(4'd0, 32'h40, 0, 3'd2, 2'b01, 4'b0101, 1'b1);
        do_read(4'd0, 32'h40, 0, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if (rd_data[0] !== 32'hFF22FF44) begin
            n_bad++; $display("FAIL strobe: got %h, required ff22ff44", rd_data[0]);
        end
        wd[0] = 32'h55;
        do_write(4'd0, 32'h24, 0, 3'd2, 2'b01, 4'hF, 1'b1);
        wd[0] = 32'h7; wd[1] = 32'h8; wd[2] = 32'h9;
        do_write(4'd0, 32'h20, 2, 3'd2, 2'b00, 4'hF, 1'b1);
        n_cmp++;
        if (b_resp !== 2'b00) begin n_bad++; $display("FAIL fixed_b: got %b, required 00", b_resp); end
        do_read(4'd0, 32'h20, 1, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if ({rd_data[0], rd_data[1]} !== {32'h9, 32'h55}) begin
            n_bad++; $display("FAIL fixed_data: got %h %h, required 9 55", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_errors;
        wd[0] = 32'hBAD;
        do_write(4'd6, 32'h1000, 0, 3'd2, 2'b01, 4'hF, 1'b1);
        n_cmp++;
        if ({b_resp, b_id} !== {2'b11, 4'd6}) begin
            n_bad++; $display("FAIL oor_b: got resp %b id %0d, required 11 id 6", b_resp, b_id);
        end
        do_read(4'd0, 32'h0, 0, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if (rd_data[0] !== 32'hA) begin
            n_bad++; $display("FAIL oor_nowrite: got %h, required a", rd_data[0]);
        end
        do_read(4'd0, 32'h1000, 0, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if ({rd_resp[0], rd_data[0]} !== {2'b11, 32'h0}) begin
            n_bad++; $display("FAIL oor_r: got resp %b data %h, required 11 0", rd_resp[0], rd_data[0]);
        end
        wd[0] = 32'h1; wd[1] = 32'h2;
        do_write(4'd0, 32'h200, 1, 3'd2, 2'b01, 4'hF, 1'b0);
        n_cmp++;
        if (b_resp !== 2'b10) begin n_bad++; $display("FAIL wlast_b: got %b, required 10", b_resp); end
        do_read(4'd0, 32'h100, 1, 3'd2, 2'b11, -1, -1);
        n_cmp++;
        if ({rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]} !== {2'b10, 2'b10, 32'd1, 32'd2}) begin
            n_bad++;
            $display("FAIL rsvd_burst: got resp %b %b data %h %h, required 10 10 1 2",
                     rd_resp[0], rd_resp[1], rd_data[0], rd_data[1]);
        end
        do_read(4'd0, 32'h100, 0, 3'd3, 2'b01, -1, -1);
        n_cmp++;
        if ({rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL size_err: got resp %b data %h, required 10 0", rd_resp[0], rd_data[0]);
        end
    endtask

    task automatic test_reset_mid_burst;
        do_read(4'd4, 32'h100, 7, 3'd2, 2'b01, -1, 2);
        n_cmp++;
        if ({rst_rvalid, rst_arready} !== 2'b00) begin
            n_bad++; $display("FAIL midrst_out: got rv %b ar %b, required 0 0", rst_rvalid, rst_arready);
        end
        ARESETn = 1;
        @(posedge ACLK); #1;
        n_cmp++;
        if (ARREADY !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b, required 1", ARREADY); end
        do_read(4'd5, 32'h100, 3, 3'd2, 2'b01, -1, -1);
        n_cmp++;
        if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3], rd_last, rd_id} !==
            {32'd1, 32'd2, 32'd3, 32'd4, 16'h0008, 4'd5}) begin
            n_bad++;
            $display("FAIL midrst_read: got %h %h %h %h last %h id %0d, required 1 2 3 4 last 0008 id 5",
                     rd_data[0], rd_data[1], rd_data[2], rd_data[3], rd_last, rd_id);
        end
    endtask

    initial begin
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
        WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
        test_reset;
        test_single;
        test_incr;
        test_wrap;
        test_strobe_fixed;
        test_errors;
        test_reset_mid_burst;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4-style memory slave that connects to the slave modport of axi_if and terminates a master's transactions in on-chip register memory.
- Independent write path (AW/W/B) and read path (AR/R).
- Supports FIXED, INCR and WRAP bursts of 1-16 beats, plus narrow transfers.
- Serves as the default bus target for master-side bring-up and verification.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, width of WDATA/RDATA; must be 32 or 64.
- ID_WIDTH, 4, width of AWID/BID/ARID/RID.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  synchronous active-low reset.
- AWID AWADDR AWLEN AWSIZE AWBURST AWVALID  in  ID_WIDTH/ADDR_WIDTH/4/3/2/1  write address channel.
- AWREADY  out  1  write address accept.
- WDATA WSTRB WLAST WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- WREADY  out  1  write data accept.
- BID BRESP BVALID  out  ID_WIDTH/2/1  write response.
- BREADY  in  1  write response accept.
- ARID ARADDR ARLEN ARSIZE ARBURST ARVALID  in  ID_WIDTH/ADDR_WIDTH/4/3/2/1  read address channel.
- ARREADY  out  1  read address accept.
- RID RDATA RRESP RLAST RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel.
- RREADY  in  1  read data accept.

Behaviour:
- Reset, sampled on the ACLK edge while ARESETn=0:
  - Both FSMs go to IDLE.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0.
  - BID, BRESP, RID, RRESP and RDATA are 0.
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst with no response; any beats already written stay written.
- All outputs are registered.
- Ready signals go high no earlier than the first edge after ARESETn rises.
- Word index = addr >> log2(DATA_WIDTH/8). An index >= MEM_DEPTH is out of range.
- Address advance per beat:
  - FIXED (00): address is unchanged.
  - INCR (01): address += 2^size.
  - WRAP (10): address += 2^size, wrapping inside an aligned window of (len+1)*2^size bytes.
  - WRAP with len not in {1,3,7,15}, or an unaligned start address: executed as INCR, response SLVERR.
  - Reserved burst (11): executed as INCR, response SLVERR.
- Size: 2^size > DATA_WIDTH/8 gives SLVERR for the whole burst; writes are suppressed and reads return 0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch id/addr/len/size/burst, clear the beat counter and error flags, go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&WREADY writes the bytes of the current word enabled by WSTRB, then advances the address and beat counter.
  - An out-of-range beat is dropped and sets the DECERR flag.
  - WLAST must equal (beat==len). A mismatch sets the SLVERR flag.
  - The burst always ends after len+1 beats, regardless of WLAST.
  - After the last beat, go to W_RESP.
  - W_RESP: BVALID=1, BID=latched id. BRESP priority is DECERR(11) > SLVERR(10) > OKAY(00).
  - BVALID and BRESP hold until BREADY, then go to W_IDLE.
  - AWREADY rises again the cycle after the B handshake.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch the request and load beat 0 into RDATA.
  - RVALID=1 from the next cycle; first-beat latency is 1 cycle.
  - R_DATA: RID=latched id; RLAST=1 only on beat len.
  - On RVALID&RREADY, load the next beat the same edge, giving back-to-back beats with no bubble.
  - RDATA, RRESP and RLAST hold stable while RREADY=0.
  - An out-of-range beat returns RDATA=0 with RRESP=DECERR. The error is per beat, not sticky.
  - After the handshake of the last beat, clear RVALID/RLAST and return to R_IDLE.
- Read and write paths run concurrently.
  - If a write beat and a read beat load hit the same word on the same edge, the read returns the pre-write data.
- Narrow reads return the full word; the master selects the byte lanes.

Test Plan:
- Single write: AW addr 0x10, len 0, size 2, INCR; W 0xDEADBEEF, strb F, WLAST=1 -> BVALID with BRESP 00, BID equal to AWID. Then read 0x10 -> RDATA 0xDEADBEEF, RLAST=1, RVALID one cycle after the AR handshake.
- INCR burst: write len 3 from 0x100 with data 1,2,3,4 -> read len 3 returns 1,2,3,4 in order with RLAST only on beat 3. Toggling RREADY 1-0-1 holds RDATA stable during the stall.
- WRAP: write 0xA,0xB,0xC,0xD to 0x00-0x0C, then WRAP read len 3 from 0x08 -> 0xC,0xD,0xA,0xB.
- Strobes and FIXED: write 0x11223344 with strb 0101 over 0xFFFFFFFF -> reads back 0xFF22FF44. A FIXED write len 2 to 0x20 leaves only the last beat's value at 0x20.
- Errors:
  - Write to index MEM_DEPTH -> BRESP 11 and memory unchanged.
  - WLAST low on the final beat -> BRESP 10.
  - ARBURST 11 -> RRESP 10.
  - ARSIZE 3 with DATA_WIDTH 32 -> RRESP 10, RDATA 0.
- Reset mid-burst: drop ARESETn during beat 2 of a len-7 read -> next edge RVALID=0 and ARREADY=0. After release ARREADY=1 and a new read completes normally.
